edge_event_arbiter: RTL and testbench
=====================================

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of level request channels (2..8).
REQ-002 Parameter ID_W, default 2, SHALL set the grant ID width (clog2(N_REQ)).
REQ-003 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 req_in  input  N_REQ  SHALL be level request lines, synchronous to clk; each 0->1 transition is one event.
REQ-006 ev_ready  input  1  SHALL be the consumer ready for the offered event.
REQ-007 ovf_clr  input  1  SHALL be a single-cycle pulse clearing all overflow flags.
REQ-008 ev_valid  output  1  SHALL flag that an event is offered on ev_id.
REQ-009 ev_id  output  ID_W  SHALL be the channel index of the offered event.
REQ-010 pend  output  N_REQ  SHALL be the pending-event vector, one bit per channel.
REQ-011 ovf  output  N_REQ  SHALL be sticky per-channel overflow flags (event lost).

Function
REQ-012 Each channel SHALL hold a registered previous sample prev[i]; edge[i] = req_in[i] & ~prev[i], combinational; prev[i] <= req_in[i] every cycle.
REQ-013 Only 0->1 transitions SHALL create events; a held-high or falling req_in creates none.
REQ-014 On a clock edge with edge[i]=1, pend[i] SHALL be set to 1.
REQ-015 The FSM SHALL have two states: IDLE (ev_valid=0) and OFFER (ev_valid=1).
REQ-016 IDLE: if any pend bit is 1, the FSM SHALL register the winner into ev_id and move to OFFER; otherwise stay IDLE.
REQ-017 Winner SHALL be the first set pend bit searching upward from rr_ptr, wrapping from N_REQ-1 to 0.
REQ-018 OFFER: ev_valid and ev_id SHALL hold stable until ev_valid & ev_ready is sampled high.
REQ-019 On handshake, pend[ev_id] SHALL clear, rr_ptr SHALL become (ev_id+1) mod N_REQ, and the FSM SHALL return to IDLE.
REQ-020 Edge on channel ev_id in the handshake cycle: set SHALL win, pend[ev_id] stays 1, ovf unchanged.
REQ-021 Edge on channel i while pend[i]=1 and pend[i] is not being cleared that cycle SHALL set ovf[i]; pend[i] stays 1.
REQ-022 ovf_clr SHALL clear all ovf bits next edge; a simultaneous set on bit i SHALL win for that bit.
REQ-023 Latency: req_in[i] first sampled high at edge E0 -> pend[i]=1 after E0; with FSM IDLE and no other pending, ev_valid=1, ev_id=i after E1.
REQ-024 Throughput SHALL be at most one event per two cycles (OFFER always returns via IDLE).
REQ-025 ev_ready while ev_valid=0 SHALL be ignored.

Reset
REQ-026 rst_n low SHALL force: prev=0, pend=0, ovf=0, rr_ptr=0, state IDLE, ev_valid=0, ev_id=0.
REQ-027 A req_in bit high at reset release SHALL count as a 0->1 event on the first edge.
REQ-028 Reset mid-OFFER SHALL drop the offered event and all pending events with no handshake.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding (IDLE=0, OFFER=1) and the N_REQ/ID_W defaults.
REQ-030 One sub-module rise_edge_det (1-bit prev register plus edge output, same reset) SHALL be instantiated per channel; arbitration and FSM stay in the top.

Verification
REQ-031 Reset, req_in=4'b0001 then ev_ready=1 -> ev_valid after 2nd edge, ev_id=0, pend=0 after handshake.
REQ-032 req_in 4'b0000->4'b1111 in one cycle, ev_ready=1 -> grants ev_id 0,1,2,3 at 2-cycle spacing, ovf=0.
REQ-033 ev_ready=0, pulse ch2 twice (0-1-0-1) -> pend[2]=1, ovf[2]=1, one event only; ovf_clr -> ovf=0.
REQ-034 ch1 rises in the handshake cycle of ev_id=1 -> pend[1] stays 1, second ev_id=1 offered, ovf[1]=0.
REQ-035 req_in held 4'b0100 -> exactly one event on ch2, none while level stays high.
REQ-036 rst_n low during OFFER with pend=4'b1010 -> ev_valid=0, pend=0 asynchronously, no event after release unless new edge.

Source files
------------

// File: rtl/edge_event_arbiter_pkg.sv
// Shared definitions for the edge event arbiter: parameter defaults and FSM encoding.
package edge_event_arbiter_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int ID_W_DEF  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/edge_event_arbiter_rise_edge_det.sv
// Per-channel rising-edge detector: one registered previous sample, combinational edge.
module rise_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  // Previous-sample register; cleared on reset so a level high at release reads as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_d;
    end
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/edge_event_arbiter.sv
// Captures rising edges on level request lines as pending events and offers them
// one at a time on a valid/ready port using round-robin arbitration.
module edge_event_arbiter
  import edge_event_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_in,
  input  logic             ev_ready,
  input  logic             ovf_clr,
  output logic             ev_valid,
  output logic [ID_W-1:0]  ev_id,
  output logic [N_REQ-1:0] pend,
  output logic [N_REQ-1:0] ovf
);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [ID_W-1:0]  r_ev_id;
  logic [ID_W-1:0]  w_ev_id_nxt;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  w_rr_nxt;
  logic [N_REQ-1:0] r_pend;
  logic [N_REQ-1:0] r_ovf;
  logic [N_REQ-1:0] w_rise;
  logic [N_REQ-1:0] w_clr;
  logic [N_REQ-1:0] w_ovf_set;
  logic             w_hs;
  logic             w_win_found;
  logic [ID_W-1:0]  w_win_id;

  for (genvar g = 0; g < N_REQ; g++) begin : g_det
    rise_edge_det u_det (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_d    (req_in[g]),
      .o_rise (w_rise[g])
    );
  end

  assign w_hs = (r_state == ST_OFFER) && ev_ready;

  // One-hot clear of the channel being handed off this cycle.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_hs && (r_ev_id == ID_W'(i))) begin
        w_clr[i] = 1'b1;
      end else begin
        w_clr[i] = 1'b0;
      end
    end
  end

  // A new edge on a channel already pending (and not being cleared) means a lost event.
  assign w_ovf_set = w_rise & r_pend & ~w_clr;

  // Round-robin search upward from rr_ptr with wrap.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = int'(r_rr_ptr) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      if (!w_win_found && r_pend[idx[ID_W-1:0]]) begin
        w_win_found = 1'b1;
        w_win_id    = idx[ID_W-1:0];
      end else begin
        w_win_found = w_win_found;
      end
    end
  end

  // Pending and sticky-overflow registers; a set always beats a clear on the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_ovf  <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_rise;
      r_ovf  <= (ovf_clr ? '0 : r_ovf) | w_ovf_set;
    end
  end

  // FSM next-state, grant ID and pointer update.
  always_comb begin
    w_state_nxt = r_state;
    w_ev_id_nxt = r_ev_id;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_win_found) begin
          w_state_nxt = ST_OFFER;
          w_ev_id_nxt = w_win_id;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OFFER: begin
        if (w_hs) begin
          w_state_nxt = ST_IDLE;
          if (r_ev_id == ID_W'(N_REQ - 1)) begin
            w_rr_nxt = '0;
          end else begin
            w_rr_nxt = r_ev_id + ID_W'(1);
          end
        end else begin
          w_state_nxt = ST_OFFER;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, grant ID and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ev_id  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ev_id  <= w_ev_id_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  assign ev_valid = (r_state == ST_OFFER);
  assign ev_id    = r_ev_id;
  assign pend     = r_pend;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: directed scenarios push expected grant IDs,
// a negedge monitor pops and compares on every handshake.
module tb_edge_event_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_in;
  logic       ev_ready;
  logic       ovf_clr;
  logic       ev_valid;
  logic [1:0] ev_id;
  logic [3:0] pend;
  logic [3:0] ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_count = 0;
  logic [1:0] exp_q[$];
  int hs_cyc[$];

  edge_event_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_in   (req_in),
    .ev_ready (ev_ready),
    .ovf_clr  (ovf_clr),
    .ev_valid (ev_valid),
    .ev_id    (ev_id),
    .pend     (pend),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake completes at the next posedge whenever valid & ready at negedge.
  always @(negedge clk) begin
    if (rst_n && ev_valid && ev_ready) begin
      hs_count++;
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got id %0d expected none", ev_id);
      end else begin
        check("grant_id", {30'd0, ev_id}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req_in   = 4'd0;
    ev_ready = 1'b0;
    ovf_clr  = 1'b0;
    tick(2);
    hs_cyc.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    rst_n    = 1'b0;
    req_in   = 4'd0;
    ev_ready = 1'b0;
    ovf_clr  = 1'b0;
    tick(2);
    check("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
    check("rst_ev_id", {30'd0, ev_id}, 32'd0);
    check("rst_pend", {28'd0, pend}, 32'd0);
    check("rst_ovf", {28'd0, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    // Single request on channel 0.
    req_in   = 4'b0001;
    ev_ready = 1'b1;
    exp_q.push_back(2'd0);
    tick(1);
    check("s1_pend_after_e0", {28'd0, pend}, 32'h1);
    check("s1_valid_after_e0", {31'd0, ev_valid}, 32'd0);
    tick(1);
    check("s1_valid_after_e1", {31'd0, ev_valid}, 32'd1);
    check("s1_id_after_e1", {30'd0, ev_id}, 32'd0);
    tick(1);
    check("s1_valid_after_hs", {31'd0, ev_valid}, 32'd0);
    check("s1_pend_after_hs", {28'd0, pend}, 32'd0);
    req_in = 4'd0;
    tick(2);

    // All four channels rise together: grants 0,1,2,3 two cycles apart.
    do_reset();
    ev_ready = 1'b1;
    req_in   = 4'b1111;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    tick(1);
    check("s2_pend_all", {28'd0, pend}, 32'hF);
    tick(10);
    check("s2_hs_total", hs_cyc.size(), 32'd4);
    if (hs_cyc.size() == 4) begin
      check("s2_spacing_01", hs_cyc[1] - hs_cyc[0], 32'd2);
      check("s2_spacing_12", hs_cyc[2] - hs_cyc[1], 32'd2);
      check("s2_spacing_23", hs_cyc[3] - hs_cyc[2], 32'd2);
    end
    check("s2_ovf", {28'd0, ovf}, 32'd0);
    check("s2_pend_end", {28'd0, pend}, 32'd0);
    req_in = 4'd0;
    ev_ready = 1'b0;

    // Second pulse on ch2 while pending: overflow, still one event; ovf_clr clears it.
    do_reset();
    req_in = 4'b0100;
    tick(1);
    req_in = 4'b0000;
    tick(1);
    req_in = 4'b0100;
    tick(1);
    check("s3_pend", {28'd0, pend}, 32'h4);
    check("s3_ovf", {28'd0, ovf}, 32'h4);
    check("s3_valid", {31'd0, ev_valid}, 32'd1);
    check("s3_id", {30'd0, ev_id}, 32'd2);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("s3_ovf_cleared", {28'd0, ovf}, 32'd0);
    exp_q.push_back(2'd2);
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
    check("s3_pend_after_hs", {28'd0, pend}, 32'd0);
    tick(4);
    check("s3_no_second_event", {31'd0, ev_valid}, 32'd0);
    req_in = 4'd0;

    // ch1 rises again in the handshake cycle of its own grant.
    do_reset();
    req_in = 4'b0010;
    tick(1);
    req_in = 4'b0000;
    tick(1);
    check("s4_offer_id", {30'd0, ev_id}, 32'd1);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd1);
    ev_ready = 1'b1;
    req_in   = 4'b0010;
    tick(1);
    check("s4_pend_kept", {28'd0, pend}, 32'h2);
    check("s4_ovf_clear", {28'd0, ovf}, 32'd0);
    check("s4_idle_between", {31'd0, ev_valid}, 32'd0);
    tick(1);
    check("s4_second_valid", {31'd0, ev_valid}, 32'd1);
    check("s4_second_id", {30'd0, ev_id}, 32'd1);
    tick(1);
    check("s4_pend_end", {28'd0, pend}, 32'd0);
    ev_ready = 1'b0;
    req_in   = 4'd0;

    // Held level on ch2: exactly one event.
    do_reset();
    begin
      int hs_before;
      hs_before = hs_count;
      ev_ready = 1'b1;
      req_in   = 4'b0100;
      exp_q.push_back(2'd2);
      tick(10);
      check("s5_one_event", hs_count - hs_before, 32'd1);
      check("s5_valid_end", {31'd0, ev_valid}, 32'd0);
      check("s5_pend_end", {28'd0, pend}, 32'd0);
    end
    ev_ready = 1'b0;

    // Asynchronous reset during an offer with two channels pending.
    do_reset();
    req_in = 4'b1010;
    tick(1);
    req_in = 4'b0000;
    tick(1);
    check("s6_valid_before", {31'd0, ev_valid}, 32'd1);
    check("s6_pend_before", {28'd0, pend}, 32'hA);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_async_valid", {31'd0, ev_valid}, 32'd0);
    check("s6_async_pend", {28'd0, pend}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(4);
    check("s6_no_event_after", {31'd0, ev_valid}, 32'd0);
    check("s6_pend_after", {28'd0, pend}, 32'd0);

    // Level already high at reset release counts as an edge.
    rst_n  = 1'b0;
    req_in = 4'b0001;
    tick(1);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("s7_pend_first_edge", {28'd0, pend}, 32'h1);
    exp_q.push_back(2'd0);
    ev_ready = 1'b1;
    tick(3);
    ev_ready = 1'b0;
    req_in   = 4'd0;
    tick(2);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
